// File: rtl/memwb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memwb_stage : MEM/WB pipeline register with load-data extraction           |
// |   Optional retire counter enabled by macro MEMWB_RETIRE_CNT_EN.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module memwb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] ALUout_i,
  input  logic [DATA_W-1:0] MEMdata_i,
  input  logic [REG_AW-1:0] WRRD_i,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [REG_AW-1:0] WRRD_o,
  output logic [DATA_W-1:0] ALUout_o,
  output logic [DATA_W-1:0] MEMdata_o,
  output logic [DATA_W-1:0] WBdata_o
`ifdef MEMWB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt_o
`endif
);

  logic              r_valid;
  logic              r_regwrite;
  logic              r_memtoreg;
  logic [REG_AW-1:0] r_wrrd;
  logic [DATA_W-1:0] r_aluout;
  logic [DATA_W-1:0] r_memdata;

  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic              w_load_en;

  assign w_load_en = !rst_i && !flush_i && !stall_i;

  // Halfword select ignores addr_lo_i[0]; misaligned halves are not flagged.
  always_comb begin
    w_word = MEMdata_i[31:0];
    w_half = addr_lo_i[1] ? w_word[31:16] : w_word[15:0];
    w_byte = w_word[7:0];
    case (addr_lo_i)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_load = MEMdata_i;
    case (funct3_i)
      3'b000:  w_load = DATA_W'($signed(w_byte));
      3'b001:  w_load = DATA_W'($signed(w_half));
      3'b010:  w_load = DATA_W'($signed(w_word));
      3'b100:  w_load = DATA_W'(w_byte);
      3'b101:  w_load = DATA_W'(w_half);
      default: w_load = MEMdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_wrrd     <= '0;
      r_aluout   <= '0;
      r_memdata  <= '0;
    end else if (!stall_i) begin
      r_valid    <= valid_i;
      r_regwrite <= RegWrite_i && valid_i && (WRRD_i != '0);
      r_memtoreg <= MemtoReg_i && valid_i;
      r_wrrd     <= WRRD_i;
      r_aluout   <= ALUout_i;
      r_memdata  <= w_load;
    end
  end

`ifdef MEMWB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_retire_cnt <= '0;
    end else if (w_load_en && valid_i) begin
      r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  assign retire_cnt_o = r_retire_cnt;
`else
  logic w_unused_load_en;
  assign w_unused_load_en = w_load_en;
`endif

  assign valid_o    = r_valid;
  assign RegWrite_o = r_regwrite;
  assign MemtoReg_o = r_memtoreg;
  assign WRRD_o     = r_wrrd;
  assign ALUout_o   = r_aluout;
  assign MEMdata_o  = r_memdata;
  assign WBdata_o   = r_memtoreg ? r_memdata : r_aluout;

endmodule
`default_nettype wire

// File: doc/memwb_stage.md
MEMWB_STAGE -- requirements
Module: memwb_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width (SHALL be >= 32).
REQ-002 Parameter REG_AW, default 5, register-index width.
REQ-003 Parameter CNT_W, default 32, retire-counter width.
REQ-004 clk_i  in  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 stall_i  in  1  hold all stage state.
REQ-007 flush_i  in  1  insert bubble.
REQ-008 valid_i  in  1  incoming MEM-stage entry is valid.
REQ-009 RegWrite_i, MemtoReg_i  in  1 each  write-back controls.
REQ-010 funct3_i  in  3  load size/sign code.
REQ-011 addr_lo_i  in  2  byte offset of load address.
REQ-012 ALUout_i, MEMdata_i  in  DATA_W each  ALU result and raw memory word.
REQ-013 WRRD_i  in  REG_AW  destination register index.
REQ-014 valid_o, RegWrite_o, MemtoReg_o  out  1 each  registered stage state.
REQ-015 WRRD_o  out  REG_AW; ALUout_o, MEMdata_o  out  DATA_W  registered state; MEMdata_o holds the extracted load value.
REQ-016 WBdata_o  out  DATA_W  write-back value: MEMdata_o if MemtoReg_o else ALUout_o (combinational from registers).
REQ-017 retire_cnt_o  out  CNT_W  retired-entry count (present only per REQ-034).

Function
REQ-018 Update priority per edge SHALL be: rst_i > flush_i > stall_i > load.
REQ-019 Load: all outputs capture inputs next edge; latency exactly 1 cycle.
REQ-020 Stall (flush_i=0): every register holds its value; WBdata_o stable.
REQ-021 Flush: valid_o, RegWrite_o, MemtoReg_o, WRRD_o, ALUout_o, MEMdata_o SHALL all become 0; flush_i and stall_i both high -> flush.
REQ-022 Captured RegWrite_o SHALL equal RegWrite_i AND valid_i AND (WRRD_i != 0).
REQ-023 Captured MemtoReg_o SHALL equal MemtoReg_i AND valid_i.
REQ-024 Load extraction at capture on MEMdata_i[31:0]: 000 LB sign-extend byte addr_lo_i; 001 LH sign-extend half addr_lo_i[1]; 010 LW word sign-extended to DATA_W; 100 LBU zero-extend byte; 101 LHU zero-extend half; other codes pass MEMdata_i unchanged.
REQ-025 Byte lane k = MEMdata_i[8k+7:8k]; LH/LHU ignore addr_lo_i[0] (misalignment not flagged).
REQ-026 Extraction SHALL apply regardless of MemtoReg_i; result unused unless MemtoReg_o=1.
REQ-027 Invalid entry (valid_i=0) loaded without flush: data fields captured, valid_o=0, RegWrite_o=0, MemtoReg_o=0.

Reset
REQ-028 rst_i high at an edge SHALL zero every register, including retire_cnt_o, regardless of stall_i/flush_i.
REQ-029 Reset mid-stall SHALL discard the held entry; first post-reset load captures normally.
REQ-030 WBdata_o SHALL be 0 in the cycle after reset.

Configuration
REQ-031 Macro MEMWB_RETIRE_CNT_EN controls the retire counter.
REQ-032 Defined: counter increments by 1 on each edge where a load occurs (rst_i=0, flush_i=0, stall_i=0) with valid_i=1.
REQ-033 Counter SHALL wrap from 2^CNT_W-1 to 0 without flag; holds on stall/flush.
REQ-034 Not defined: retire_cnt_o port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 Load: valid_i=1, RegWrite_i=1, MemtoReg_i=0, WRRD_i=5, ALUout_i=0x00001234 -> next cycle RegWrite_o=1, WRRD_o=5, WBdata_o=0x00001234.
REQ-036 Extraction: MEMdata_i=0x80FF7F01, MemtoReg_i=1; funct3/addr_lo 000/01 -> 0x0000007F; 000/11 -> 0xFFFFFF80; 100/10 -> 0x000000FF; 001/10 -> 0xFFFF80FF; 101/00 -> 0x00007F01.
REQ-037 x0 and invalid: WRRD_i=0 RegWrite_i=1 -> RegWrite_o=0; valid_i=0 -> valid_o=0, RegWrite_o=0.
REQ-038 Stall/flush: load entry A, stall 3 cycles with changing inputs -> outputs hold A; stall_i=flush_i=1 -> all outputs 0 next cycle.
REQ-039 Reset mid-stall: entry held, rst_i=1 one cycle -> all outputs 0 (retire_cnt_o=0); next load captured.
REQ-040 Counter (MEMWB_RETIRE_CNT_EN, CNT_W=4): 17 valid loads with 2 stalls and 1 flush interleaved -> retire_cnt_o=1 (wrapped); undefined macro -> elaborates without retire_cnt_o.
